uart_tx: RTL

UART transmitter; the transmit-side counterpart of uart_rx and frame-compatible with it.
- Accepts a byte through a valid/ready handshake.
- Serialises it LSB-first on tx_pin as start, data, optional odd parity and stop bits.
- Bit timing is derived from the shared tick_16x strobe.
- Sits between the host/bus interface and the serial pin; its pin can be looped directly into uart_rx for self-test.

---
 rtl/uart_tx.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter, start / LSB-first data / optional parity / stop, timed by tick_16x.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry holding FIFO between the handshake and the shifter.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OS_RATE    = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic                 parity_enable,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_pin,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int OS_W  = (OS_RATE > 1) ? $clog2(OS_RATE) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OS_RATE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);

  if (STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
    $error("uart_tx: STOP_BITS must be 1 or 2 and FIFO_DEPTH a power of two >= 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q;
  logic [OS_W-1:0]      os_count_q;
  logic [BIT_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 tx_pin_q;
  logic                 tx_busy_q;
  logic                 tx_done_q;
  logic                 idle_q;
  logic                 bit_end;

  // Frame source for the shifter: either the live handshake or the FIFO head.
  logic                 ld_valid;
  logic [DATA_BITS-1:0] ld_data;
  logic                 ld_par_en;

`ifdef UART_TX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_BITS:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW:0]        count_q;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;

  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = tx_valid && !full;
  assign pop      = idle_q && !empty;
  assign tx_ready = !full;
  assign ld_valid = pop;
  assign {ld_par_en, ld_data} = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {parity_enable, tx_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
`else
  assign tx_ready  = idle_q;
  assign ld_valid  = tx_valid && idle_q;
  assign ld_data   = tx_data;
  assign ld_par_en = parity_enable;
`endif

  assign bit_end = tick_16x && (os_count_q == OS_LAST);
  assign shift_d = shift_q >> 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      os_count_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_pin_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      tx_done_q <= 1'b0;
      // A tick arriving together with the load is deliberately not counted.
      if (state_q != IDLE && tick_16x) begin
        os_count_q <= bit_end ? '0 : os_count_q + OS_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (ld_valid) begin
            shift_q    <= ld_data;
            par_en_q   <= ld_par_en;
            par_bit_q  <= (^ld_data) ^ PAR_ODD;
            os_count_q <= '0;
            bit_idx_q  <= '0;
            tx_pin_q   <= 1'b0;
            tx_busy_q  <= 1'b1;
            idle_q     <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_pin_q <= shift_q[0];
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_q == DATA_LAST) begin
              bit_idx_q <= '0;
              if (par_en_q) begin
                tx_pin_q <= par_bit_q;
                state_q  <= PARITY;
              end else begin
                tx_pin_q <= 1'b1;
                state_q  <= STOP;
              end
            end else begin
              shift_q   <= shift_d;
              tx_pin_q  <= shift_d[0];
              bit_idx_q <= bit_idx_q + BIT_W'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx_pin_q <= 1'b1;
            state_q  <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_idx_q == STOP_LAST) begin
              bit_idx_q <= '0;
              tx_done_q <= 1'b1;
              tx_busy_q <= 1'b0;
              idle_q    <= 1'b1;
              state_q   <= IDLE;
            end else begin
              bit_idx_q <= bit_idx_q + BIT_W'(1);
            end
          end
        end
        default: begin
          tx_pin_q  <= 1'b1;
          tx_busy_q <= 1'b0;
          idle_q    <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign tx_pin  = tx_pin_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

endmodule
